ni_bless_local: RTL

- Local-port network interface (NI) for the bufferless BLESS router.
- Injection side: accepts flits from the core through a valid/ready handshake and buffers them in an injection FIFO. It drives the router's local input port and retransmits any flit the router does not grant.
- Ejection side: captures flits leaving the router's local output port into an ejection FIFO and presents them to the core with valid/ready.
- Sits between the processing element and router port 4.

---
 rtl/ni_bless_local.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ni_bless_local.sv
// Local-port network interface for the bufferless BLESS router: injection FIFO with
// send/wait retransmission toward router port 4, and ejection FIFO toward the core.
module ni_bless_local #(
    parameter int DATA_WIDTH = 32,
    parameter int VLD_BIT    = 31,
    parameter int INJ_DEPTH  = 4,
    parameter int EJ_DEPTH   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_n_rst,
    input  logic [DATA_WIDTH-1:0] i_core_inj_flit,
    input  logic                  i_core_inj_valid,
    output logic                  o_core_inj_ready,
    output logic [DATA_WIDTH-1:0] o_rtr_data_in,
    input  logic                  i_rtr_inj_grant,
    input  logic [DATA_WIDTH-1:0] i_rtr_data_out,
    output logic [DATA_WIDTH-1:0] o_core_ej_flit,
    output logic                  o_core_ej_valid,
    input  logic                  i_core_ej_ready,
    output logic [CNT_WIDTH-1:0]  o_retry_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic                  o_drop_flag
);
    localparam int IA = $clog2(INJ_DEPTH);
    localparam int EA = $clog2(EJ_DEPTH);
    localparam logic [IA:0]   INJ_FULL = (IA+1)'(INJ_DEPTH);
    localparam logic [IA:0]   INJ_ONE  = (IA+1)'(1);
    localparam logic [IA-1:0] INJ_INC  = IA'(1);
    localparam logic [EA:0]   EJ_FULL  = (EA+1)'(EJ_DEPTH);
    localparam logic [EA:0]   EJ_ONE   = (EA+1)'(1);
    localparam logic [EA-1:0] EJ_INC   = EA'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Injection side
    logic [DATA_WIDTH-1:0] r_inj_mem [INJ_DEPTH];
    logic [IA-1:0]         r_inj_wptr, r_inj_rptr;
    logic [IA:0]           r_inj_cnt;
    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_rtr_data_in;
    logic [CNT_WIDTH-1:0]  r_retry_cnt;

    logic                  w_inj_full, w_inj_push, w_inj_pop;
    logic [1:0]            w_state_nxt;
    logic [IA-1:0]         w_tx_ptr;
    logic [DATA_WIDTH-1:0] w_tx_flit;

    assign w_inj_full       = (r_inj_cnt == INJ_FULL);
    assign o_core_inj_ready = !w_inj_full;
    assign w_inj_push       = i_core_inj_valid && !w_inj_full;
    assign w_inj_pop        = (r_state == ST_WAIT) && i_rtr_inj_grant;

    // After a grant the next flit to send is the one behind the popped head.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_ptr    = r_inj_rptr;
        case (r_state)
            ST_IDLE: if (r_inj_cnt != '0) w_state_nxt = ST_SEND;
            ST_SEND: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_rtr_inj_grant) begin
                    w_tx_ptr    = r_inj_rptr + INJ_INC;
                    w_state_nxt = (r_inj_cnt > INJ_ONE) ? ST_SEND : ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_tx_flit          = r_inj_mem[w_tx_ptr];
        w_tx_flit[VLD_BIT] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_inj_push) r_inj_mem[r_inj_wptr] <= i_core_inj_flit;
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_inj_wptr    <= '0;
            r_inj_rptr    <= '0;
            r_inj_cnt     <= '0;
            r_state       <= ST_IDLE;
            r_rtr_data_in <= '0;
            r_retry_cnt   <= '0;
        end else begin
            if (w_inj_push) r_inj_wptr <= r_inj_wptr + INJ_INC;
            if (w_inj_pop)  r_inj_rptr <= r_inj_rptr + INJ_INC;
            case ({w_inj_push, w_inj_pop})
                2'b10:   r_inj_cnt <= r_inj_cnt + INJ_ONE;
                2'b01:   r_inj_cnt <= r_inj_cnt - INJ_ONE;
                default: r_inj_cnt <= r_inj_cnt;
            endcase
            r_state       <= w_state_nxt;
            r_rtr_data_in <= (w_state_nxt == ST_SEND) ? w_tx_flit : '0;
            if ((r_state == ST_WAIT) && !i_rtr_inj_grant) r_retry_cnt <= sat_inc(r_retry_cnt);
        end
    end

    assign o_rtr_data_in = r_rtr_data_in;
    assign o_retry_cnt   = r_retry_cnt;

    // Ejection side
    logic [DATA_WIDTH-1:0] r_ej_mem [EJ_DEPTH];
    logic [EA-1:0]         r_ej_wptr, r_ej_rptr;
    logic [EA:0]           r_ej_cnt;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic                  r_drop_flag;
    logic                  w_ej_in, w_ej_full, w_ej_rd, w_ej_wr, w_ej_drop;

    assign w_ej_in   = i_rtr_data_out[VLD_BIT];
    assign w_ej_full = (r_ej_cnt == EJ_FULL);
    assign w_ej_rd   = o_core_ej_valid && i_core_ej_ready;
    assign w_ej_wr   = w_ej_in && (!w_ej_full || w_ej_rd);
    assign w_ej_drop = w_ej_in && w_ej_full && !w_ej_rd;

    always_ff @(posedge i_clk) begin
        if (w_ej_wr) r_ej_mem[r_ej_wptr] <= i_rtr_data_out;
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_ej_wptr   <= '0;
            r_ej_rptr   <= '0;
            r_ej_cnt    <= '0;
            r_drop_cnt  <= '0;
            r_drop_flag <= 1'b0;
        end else begin
            if (w_ej_wr) r_ej_wptr <= r_ej_wptr + EJ_INC;
            if (w_ej_rd) r_ej_rptr <= r_ej_rptr + EJ_INC;
            case ({w_ej_wr, w_ej_rd})
                2'b10:   r_ej_cnt <= r_ej_cnt + EJ_ONE;
                2'b01:   r_ej_cnt <= r_ej_cnt - EJ_ONE;
                default: r_ej_cnt <= r_ej_cnt;
            endcase
            if (w_ej_drop) begin
                r_drop_cnt  <= sat_inc(r_drop_cnt);
                r_drop_flag <= 1'b1;
            end
        end
    end

    assign o_core_ej_valid = (r_ej_cnt != '0);
    assign o_core_ej_flit  = o_core_ej_valid ? r_ej_mem[r_ej_rptr] : '0;
    assign o_drop_cnt      = r_drop_cnt;
    assign o_drop_flag     = r_drop_flag;
endmodule
